// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single registered owner of the RAM strobes, arbitrating CPU access against loader writes.
module mem_arbiter #(
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic          CLK,
    input  logic          nCLR,
    input  logic          run,
    input  logic          cpu_cs,
    input  logic          cpu_nce,
    input  logic [AW-1:0] cpu_addr,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          ld_err,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_cs,
    output logic          ram_nwe,
    output logic          ram_nce,
    output logic [AW:0]   ld_count,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CPU      = 3'd1,
        LD_SETUP = 3'd2,
        LD_WRITE = 3'd3,
        LD_RECOV = 3'd4
    } state_t;

    localparam logic [AW:0] countMax = (AW+1)'(DEPTH);
    localparam logic [AW:0] countOne = (AW+1)'(1);

    state_t        state;
    state_t        nextState;
    logic [AW-1:0] addrNext;
    logic [DW-1:0] wdataNext;
    logic          csNext;
    logic          nweNext;
    logic          nceNext;
    logic          readyNext;
    logic          errNext;
    logic [AW:0]   countNext;

    // Every output is computed here one cycle ahead and registered below,
    // so the RAM strobes never see combinational glitches.
    always_comb begin
        nextState = state;
        addrNext  = ram_addr;
        wdataNext = ram_wdata;
        csNext    = ram_cs;
        nweNext   = 1'b1;
        nceNext   = ram_nce;
        readyNext = 1'b0;
        errNext   = 1'b0;
        countNext = ld_count;
        case (state)
            IDLE: begin
                csNext  = 1'b0;
                nceNext = 1'b1;
                if (run && cpu_cs) begin
                    nextState = CPU;
                    addrNext  = cpu_addr;
                    csNext    = 1'b1;
                    nceNext   = cpu_nce;
                end else if (!run && ld_valid) begin
                    nextState = LD_SETUP;
                    addrNext  = ld_addr;
                    wdataNext = ld_data;
                    csNext    = 1'b1;
                    nceNext   = 1'b1;
                end else if (run && ld_valid) begin
                    errNext = 1'b1;
                end
            end
            CPU: begin
                if (run && cpu_cs) begin
                    addrNext = cpu_addr;
                    csNext   = 1'b1;
                    nceNext  = cpu_nce;
                end else begin
                    nextState = IDLE;
                    csNext    = 1'b0;
                    nceNext   = 1'b1;
                end
            end
            LD_SETUP: begin
                nextState = LD_WRITE;
                csNext    = 1'b1;
                nceNext   = 1'b1;
                nweNext   = 1'b0;
            end
            LD_WRITE: begin
                // Count only once the write pulse has fully completed.
                nextState = LD_RECOV;
                csNext    = 1'b0;
                nceNext   = 1'b1;
                readyNext = 1'b1;
                if (ld_count != countMax) begin
                    countNext = ld_count + countOne;
                end
            end
            LD_RECOV: begin
                nextState = IDLE;
                csNext    = 1'b0;
                nceNext   = 1'b1;
            end
            default: begin
                nextState = IDLE;
                csNext    = 1'b0;
                nceNext   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state     <= IDLE;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_cs    <= 1'b0;
            ram_nwe   <= 1'b1;
            ram_nce   <= 1'b1;
            ld_ready  <= 1'b0;
            ld_err    <= 1'b0;
            ld_count  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= nextState;
            ram_addr  <= addrNext;
            ram_wdata <= wdataNext;
            ram_cs    <= csNext;
            ram_nwe   <= nweNext;
            ram_nce   <= nceNext;
            ld_ready  <= readyNext;
            ld_err    <= errNext;
            ld_count  <= countNext;
            busy      <= (nextState != IDLE);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter.
module tb_mem_arbiter;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          CLK = 1'b0;
    logic          nCLR = 1'b0;
    logic          run = 1'b0;
    logic          cpu_cs = 1'b0;
    logic          cpu_nce = 1'b1;
    logic [AW-1:0] cpu_addr = '0;
    logic          ld_valid = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_ready;
    logic          ld_err;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_cs;
    logic          ram_nwe;
    logic          ram_nce;
    logic [AW:0]   ld_count;
    logic          busy;

    mem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .nCLR(nCLR), .run(run), .cpu_cs(cpu_cs), .cpu_nce(cpu_nce),
        .cpu_addr(cpu_addr), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_err(ld_err), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_cs(ram_cs), .ram_nwe(ram_nwe), .ram_nce(ram_nce), .ld_count(ld_count), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int writes = 0;
    int readys = 0;
    int errs = 0;
    logic [AW+DW-1:0] expQ[$];
    logic [DW-1:0]    mem[DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock, sampled 1ns after the edge; acts as RAM model and write monitor.
    task automatic tick();
        logic [AW+DW-1:0] e;
        @(posedge CLK);
        #1;
        cycle++;
        if (ld_ready) readys++;
        if (ld_err) errs++;
        check("nwe_nce_overlap", {31'b0, ~ram_nwe & ~ram_nce}, 32'd0);
        if (ram_cs && !ram_nwe) begin
            writes++;
            mem[ram_addr] = ram_wdata;
            check("write_expected", {31'b0, expQ.size() > 0}, 32'd1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("write_addr_data", {20'b0, ram_addr, ram_wdata}, {20'b0, e});
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lastReady;
        int w0;
        int e0;
        int r0;
        logic got;
        logic [DW-1:0] last0;
        logic [DW-1:0] last1;
        lastReady = 0;
        last0 = '0;
        last1 = '0;

        // Reset values
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_cs", ram_cs, 0);
        check("rst_nwe", ram_nwe, 1);
        check("rst_nce", ram_nce, 1);
        check("rst_count", ld_count, 0);
        check("rst_addr_data", {ram_addr, ram_wdata}, 0);
        check("rst_ready_err", {ld_ready, ld_err}, 0);
        nCLR = 1'b1;
        tick();

        // Single loader write
        run = 1'b0; ld_valid = 1'b1; ld_addr = 4'd3; ld_data = 8'h5A;
        expQ.push_back({4'd3, 8'h5A});
        tick();
        check("t1_setup_cs", ram_cs, 1);
        check("t1_setup_nwe", ram_nwe, 1);
        check("t1_setup_busy", busy, 1);
        tick();
        check("t1_write_nwe", ram_nwe, 0);
        check("t1_write_addr", ram_addr, 3);
        check("t1_write_data", ram_wdata, 8'h5A);
        check("t1_write_ready", ld_ready, 0);
        tick();
        check("t1_recov_ready", ld_ready, 1);
        check("t1_recov_nwe_cs", {ram_nwe, ram_cs}, 2'b10);
        check("t1_count", ld_count, 1);
        ld_valid = 1'b0;
        tick();
        check("t1_idle_ready", ld_ready, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_writes", writes, 1);

        // Stream 18 bytes with ld_valid held; saturation and overwrite
        ld_valid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            ld_addr = AW'(i % 16);
            ld_data = DW'(i * 37 + 11);
            if (i == 16) last0 = ld_data;
            if (i == 17) last1 = ld_data;
            expQ.push_back({ld_addr, ld_data});
            got = 1'b0;
            for (int k = 0; k < 8 && !got; k++) begin
                tick();
                got = ld_ready;
            end
            check("stream_ready", got, 1);
            if (i > 0) check("stream_period", cycle - lastReady, 4);
            lastReady = cycle;
            check("stream_count", ld_count, (i + 2 > DEPTH) ? DEPTH : i + 2);
        end
        ld_valid = 1'b0;
        tick();
        check("stream_final_count", ld_count, 16);
        check("stream_mem0", mem[0], last0);
        check("stream_mem1", mem[1], last1);

        // CPU access
        run = 1'b1; cpu_cs = 1'b1; cpu_nce = 1'b0; cpu_addr = 4'd9;
        tick();
        check("cpu_cs", ram_cs, 1);
        check("cpu_nce", ram_nce, 0);
        check("cpu_addr", ram_addr, 9);
        check("cpu_nwe", ram_nwe, 1);
        check("cpu_busy", busy, 1);
        cpu_cs = 1'b0; cpu_nce = 1'b1;
        tick();
        check("cpu_exit_cs", ram_cs, 0);
        check("cpu_exit_nce", ram_nce, 1);
        check("cpu_exit_busy", busy, 0);

        // Loader rejected in run mode
        w0 = writes; e0 = errs;
        ld_valid = 1'b1; ld_addr = 4'd4; ld_data = 8'hEE;
        repeat (3) begin
            tick();
            check("err_pulse", ld_err, 1);
        end
        ld_valid = 1'b0;
        tick();
        check("err_clear", ld_err, 0);
        check("err_count", errs - e0, 3);
        check("err_no_write", writes - w0, 0);
        check("err_ld_count", ld_count, 16);

        // run rising during a write: write completes, then CPU granted
        run = 1'b0; ld_valid = 1'b1; ld_addr = 4'd5; ld_data = 8'hC3;
        expQ.push_back({4'd5, 8'hC3});
        tick();
        run = 1'b1; cpu_cs = 1'b1; cpu_nce = 1'b0; cpu_addr = 4'd2;
        tick();
        check("race_write_nwe", ram_nwe, 0);
        check("race_write_nce", ram_nce, 1);
        tick();
        check("race_ready", ld_ready, 1);
        ld_valid = 1'b0;
        tick();
        check("race_idle_cs", ram_cs, 0);
        check("race_idle_busy", busy, 0);
        tick();
        check("race_cpu_cs", ram_cs, 1);
        check("race_cpu_nce", ram_nce, 0);
        check("race_cpu_addr", ram_addr, 2);
        cpu_cs = 1'b0; cpu_nce = 1'b1; run = 1'b0;
        tick();

        // Reset mid-write
        r0 = readys;
        ld_valid = 1'b1; ld_addr = 4'd7; ld_data = 8'h11;
        expQ.push_back({4'd7, 8'h11});
        tick();
        tick();
        check("mid_write_nwe", ram_nwe, 0);
        #2;
        nCLR = 1'b0;
        #1;
        check("async_nwe", ram_nwe, 1);
        check("async_cs", ram_cs, 0);
        check("async_busy", busy, 0);
        check("async_count", ld_count, 0);
        ld_valid = 1'b0;
        repeat (2) tick();
        nCLR = 1'b1;
        tick();
        check("post_rst_ready", readys - r0, 0);
        check("post_rst_count", ld_count, 0);
        check("queue_drained", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
